// File: rtl/hazard_scoreboard_unit_pkg.sv
// Shared types and constants for the hazard/scoreboard unit.
// Optional statistics counters are enabled with the HAZARD_STATS_EN macro.
package hazard_pkg;

  // Operand source select driven to the ID/EX operand muxes.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10,
    FWD_EX  = 2'b11
  } fwd_sel_e;

  // Control state of the unit.
  typedef enum logic [1:0] {
    HZ_RUN,
    HZ_MEM_WAIT,
    HZ_FLUSH
  } hz_state_e;

  localparam int FCNT_W  = 3;   // holds FLUSH_CYC up to 7
  localparam int WCNT_W  = 8;   // holds MAX_WAIT up to 255
  localparam int STATS_W = 16;

  // Saturating increment used by the statistics counters.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Bundle of the pipeline-facing signals of the hazard/scoreboard unit.
// master = pipeline side, slave = hazard unit. Statistics outputs exist
// only when HAZARD_STATS_EN is defined.
interface hazard_scoreboard_unit_if #(
  parameter int REG_ADDR_W = 2
);
  localparam int NUM_REGS = 1 << REG_ADDR_W;

  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  ex_reg_write;
  logic                  mem_reg_write;
  logic                  wb_reg_write;
  logic                  ex_mem_read;
  logic                  mem_req;
  logic                  mem_ack;
  logic                  branch_taken;

  logic [1:0]            forward_a;
  logic [1:0]            forward_b;
  logic                  stall;
  logic                  flush;
  logic [NUM_REGS-1:0]   busy_regs;
  logic                  mem_timeout;
`ifdef HAZARD_STATS_EN
  logic [15:0]           stall_cycles;
  logic [15:0]           fwd_events;
`endif

  modport master (
    output id_valid, id_rs, id_rt, ex_rd, mem_rd, wb_rd,
           ex_reg_write, mem_reg_write, wb_reg_write,
           ex_mem_read, mem_req, mem_ack, branch_taken,
    input  forward_a, forward_b, stall, flush, busy_regs, mem_timeout
`ifdef HAZARD_STATS_EN
    , input stall_cycles, fwd_events
`endif
  );

  modport slave (
    input  id_valid, id_rs, id_rt, ex_rd, mem_rd, wb_rd,
           ex_reg_write, mem_reg_write, wb_reg_write,
           ex_mem_read, mem_req, mem_ack, branch_taken,
    output forward_a, forward_b, stall, flush, busy_regs, mem_timeout
`ifdef HAZARD_STATS_EN
    , output stall_cycles, fwd_events
`endif
  );

endinterface

// File: rtl/hazard_scoreboard_unit_fwd_sel.sv
// Priority forwarding select for one source operand: EX > MEM > WB > regfile.
// Forced to the regfile while the pipeline is stalled.
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 2,
  parameter bit IGNORE_REG0 = 1'b0
) (
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_ex_wr,
  input  logic                  i_mem_wr,
  input  logic                  i_wb_wr,
  input  logic                  i_force_rf,
  output fwd_sel_e              o_sel
);

  logic w_src_ok;

  // Register 0 is hard-wired when IGNORE_REG0 is set, so it never forwards.
  assign w_src_ok = !(IGNORE_REG0 && (i_src == '0));

  // Highest-priority producing stage wins.
  always_comb begin
    // NOTE: combinational blocks assign a default first so no path leaves o_sel unassigned (no latch).
    o_sel = FWD_RF;
    if (i_force_rf || !w_src_ok)             o_sel = FWD_RF;
    else if (i_ex_wr  && (i_ex_rd  == i_src)) o_sel = FWD_EX;
    else if (i_mem_wr && (i_mem_rd == i_src)) o_sel = FWD_MEM;
    else if (i_wb_wr  && (i_wb_rd  == i_src)) o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit beside ID: operand forwarding, load-use stall, branch flush
// and a register scoreboard for one outstanding multi-cycle memory load.
// Define HAZARD_STATS_EN to add saturating stall/forward event counters.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 2,
  parameter bit IGNORE_REG0 = 1'b0,
  parameter int FLUSH_CYC   = 2,
  parameter int MAX_WAIT    = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  hazard_scoreboard_unit_if.slave bus
);

  localparam int NUM_REGS = 1 << REG_ADDR_W;
  localparam logic [FCNT_W-1:0] FLUSH_INIT = FCNT_W'(FLUSH_CYC);
  localparam logic [WCNT_W-1:0] WAIT_LIMIT = WCNT_W'(MAX_WAIT);

  hz_state_e             r_state,    w_state_nxt;
  logic [FCNT_W-1:0]     r_fcnt,     w_fcnt_nxt;
  logic [WCNT_W-1:0]     r_wcnt,     w_wcnt_nxt;
  logic                  r_timeout,  w_timeout_nxt;
  logic [NUM_REGS-1:0]   r_busy,     w_busy_nxt;
  logic [REG_ADDR_W-1:0] r_pend_rd,  w_pend_rd_nxt;
  logic                  r_pend_vld, w_pend_vld_nxt;

  logic     w_rs_ok, w_rt_ok, w_mem_rd_ok;
  logic     w_load_use, w_sb_hit, w_flush, w_stall;
  fwd_sel_e w_fwd_a, w_fwd_b;

  assign w_rs_ok     = !(IGNORE_REG0 && (bus.id_rs  == '0));
  assign w_rt_ok     = !(IGNORE_REG0 && (bus.id_rt  == '0));
  assign w_mem_rd_ok = !(IGNORE_REG0 && (bus.mem_rd == '0));

  assign w_load_use = bus.id_valid && bus.ex_mem_read &&
                      ((w_rs_ok && (bus.ex_rd == bus.id_rs)) ||
                       (w_rt_ok && (bus.ex_rd == bus.id_rt)));
  assign w_sb_hit   = bus.id_valid &&
                      ((w_rs_ok && r_busy[bus.id_rs]) || (w_rt_ok && r_busy[bus.id_rt]));

  // Flush comes straight from state, so it is already a registered signal.
  assign w_flush = (r_state == HZ_FLUSH);
  assign w_stall = ((w_load_use || w_sb_hit) && !w_flush) || (r_state == HZ_MEM_WAIT);

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W), .IGNORE_REG0(IGNORE_REG0)) u_fwd_rs (
    .i_src(bus.id_rs), .i_ex_rd(bus.ex_rd), .i_mem_rd(bus.mem_rd), .i_wb_rd(bus.wb_rd),
    .i_ex_wr(bus.ex_reg_write), .i_mem_wr(bus.mem_reg_write), .i_wb_wr(bus.wb_reg_write),
    .i_force_rf(w_stall), .o_sel(w_fwd_a)
  );

  hazard_fwd_sel #(.REG_ADDR_W(REG_ADDR_W), .IGNORE_REG0(IGNORE_REG0)) u_fwd_rt (
    .i_src(bus.id_rt), .i_ex_rd(bus.ex_rd), .i_mem_rd(bus.mem_rd), .i_wb_rd(bus.wb_rd),
    .i_ex_wr(bus.ex_reg_write), .i_mem_wr(bus.mem_reg_write), .i_wb_wr(bus.wb_reg_write),
    .i_force_rf(w_stall), .o_sel(w_fwd_b)
  );

  // Control FSM next state: RUN / MEM_WAIT / FLUSH with their counters.
  always_comb begin
    w_state_nxt   = r_state;
    w_fcnt_nxt    = r_fcnt;
    w_wcnt_nxt    = r_wcnt;
    w_timeout_nxt = r_timeout;
    case (r_state)
      HZ_RUN: begin
        if (bus.branch_taken) begin
          w_state_nxt = HZ_FLUSH;
          w_fcnt_nxt  = FLUSH_INIT;
        end else if (bus.mem_req && !bus.mem_ack) begin
          w_state_nxt = HZ_MEM_WAIT;
          w_wcnt_nxt  = '0;
        end
      end
      HZ_MEM_WAIT: begin
        // EX is frozen here, so a branch_taken is not acted upon.
        if (bus.mem_ack) begin
          w_state_nxt = HZ_RUN;
        end else begin
          if (r_wcnt == WAIT_LIMIT) w_timeout_nxt = 1'b1;
          if (r_wcnt != '1)         w_wcnt_nxt    = r_wcnt + 1'b1;
        end
      end
      HZ_FLUSH: begin
        if (bus.branch_taken) begin
          w_fcnt_nxt = FLUSH_INIT;
        end else if (r_fcnt <= FCNT_W'(1)) begin
          w_state_nxt = HZ_RUN;
          w_fcnt_nxt  = '0;
        end else begin
          w_fcnt_nxt = r_fcnt - 1'b1;
        end
      end
      default: w_state_nxt = HZ_RUN;
    endcase
  end

  // Scoreboard next state: the ack retires the old load before a new one is marked.
  always_comb begin
    w_busy_nxt     = r_busy;
    w_pend_rd_nxt  = r_pend_rd;
    w_pend_vld_nxt = r_pend_vld;
    if (bus.mem_ack && r_pend_vld) begin
      w_busy_nxt[r_pend_rd] = 1'b0;
      w_pend_vld_nxt        = 1'b0;
    end
    if (bus.mem_req && bus.mem_reg_write && w_mem_rd_ok) begin
      w_busy_nxt[bus.mem_rd] = 1'b1;
      w_pend_rd_nxt          = bus.mem_rd;
      w_pend_vld_nxt         = 1'b1;
    end
  end

  // State registers with synchronous reset; a reset drops any pending load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_state    <= HZ_RUN;
      r_fcnt     <= '0;
      r_wcnt     <= '0;
      r_timeout  <= 1'b0;
      r_busy     <= '0;
      r_pend_rd  <= '0;
      r_pend_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fcnt     <= w_fcnt_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_timeout  <= w_timeout_nxt;
      r_busy     <= w_busy_nxt;
      r_pend_rd  <= w_pend_rd_nxt;
      r_pend_vld <= w_pend_vld_nxt;
    end
  end

  assign bus.forward_a   = w_fwd_a;
  assign bus.forward_b   = w_fwd_b;
  assign bus.stall       = w_stall;
  assign bus.flush       = w_flush;
  assign bus.busy_regs   = r_busy;
  assign bus.mem_timeout = r_timeout;

`ifdef HAZARD_STATS_EN
  logic [STATS_W-1:0] r_stall_cycles;
  logic [STATS_W-1:0] r_fwd_events;

  // Saturating event counters: stalled cycles and cycles with any forward.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_fwd_events   <= '0;
    end else begin
      r_stall_cycles <= sat_inc(r_stall_cycles, w_stall);
      r_fwd_events   <= sat_inc(r_fwd_events, (w_fwd_a != FWD_RF) || (w_fwd_b != FWD_RF));
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.fwd_events   = r_fwd_events;
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit. Two instances share the
// same stimulus: one with IGNORE_REG0=0 and one with IGNORE_REG0=1. Both are
// compared every cycle against a behavioural model, plus directed checks.
module tb_hazard_scoreboard_unit;
  import hazard_pkg::*;

  localparam int W         = 2;
  localparam int FLUSH_CYC = 2;
  localparam int MAX_WAIT  = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hazard_scoreboard_unit_if #(.REG_ADDR_W(W)) bus0 ();
  hazard_scoreboard_unit_if #(.REG_ADDR_W(W)) bus1 ();

  hazard_scoreboard_unit #(.REG_ADDR_W(W), .IGNORE_REG0(1'b0), .FLUSH_CYC(FLUSH_CYC), .MAX_WAIT(MAX_WAIT))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  hazard_scoreboard_unit #(.REG_ADDR_W(W), .IGNORE_REG0(1'b1), .FLUSH_CYC(FLUSH_CYC), .MAX_WAIT(MAX_WAIT))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  assign bus1.id_valid      = bus0.id_valid;
  assign bus1.id_rs         = bus0.id_rs;
  assign bus1.id_rt         = bus0.id_rt;
  assign bus1.ex_rd         = bus0.ex_rd;
  assign bus1.mem_rd        = bus0.mem_rd;
  assign bus1.wb_rd         = bus0.wb_rd;
  assign bus1.ex_reg_write  = bus0.ex_reg_write;
  assign bus1.mem_reg_write = bus0.mem_reg_write;
  assign bus1.wb_reg_write  = bus0.wb_reg_write;
  assign bus1.ex_mem_read   = bus0.ex_mem_read;
  assign bus1.mem_req       = bus0.mem_req;
  assign bus1.mem_ack       = bus0.mem_ack;
  assign bus1.branch_taken  = bus0.branch_taken;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model, per instance k (k==1 ignores register 0).
  int       m_flush_left [2];   // flush cycles still to show
  bit       m_waiting    [2];   // waiting on a multi-cycle access
  int       m_wait_cnt   [2];
  bit       m_tout       [2];
  bit [3:0] m_busy       [2];
  int       m_pend       [2];   // pending load destination, -1 if none
  int       m_stall_cnt  [2];
  int       m_fwd_cnt    [2];
  bit       e_stall      [2];
  int       e_fa         [2];
  int       e_fb         [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit mm(int k, logic [1:0] rd, logic [1:0] src);
    return (rd == src) && !(k == 1 && src == 2'd0);
  endfunction

  function automatic int mfwd(int k, logic [1:0] src, bit st);
    if (st) return 0;
    if (bus0.ex_reg_write  && mm(k, bus0.ex_rd,  src)) return 3;
    if (bus0.mem_reg_write && mm(k, bus0.mem_rd, src)) return 1;
    if (bus0.wb_reg_write  && mm(k, bus0.wb_rd,  src)) return 2;
    return 0;
  endfunction

  function automatic bit busy_of(int k, logic [1:0] r);
    return m_busy[k][r] && !(k == 1 && r == 2'd0);
  endfunction

  task automatic model_clear(input int k);
    m_flush_left[k] = 0; m_waiting[k] = 0; m_wait_cnt[k] = 0; m_tout[k] = 0;
    m_busy[k] = '0; m_pend[k] = -1; m_stall_cnt[k] = 0; m_fwd_cnt[k] = 0;
  endtask

  task automatic compute_expected();
    for (int k = 0; k < 2; k++) begin
      bit lu, sb;
      lu = bus0.id_valid && bus0.ex_mem_read &&
           (mm(k, bus0.ex_rd, bus0.id_rs) || mm(k, bus0.ex_rd, bus0.id_rt));
      sb = bus0.id_valid && (busy_of(k, bus0.id_rs) || busy_of(k, bus0.id_rt));
      e_stall[k] = ((lu || sb) && (m_flush_left[k] == 0)) || m_waiting[k];
      e_fa[k]    = mfwd(k, bus0.id_rs, e_stall[k]);
      e_fb[k]    = mfwd(k, bus0.id_rt, e_stall[k]);
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        model_clear(k);
      end else begin
        if (e_stall[k] && m_stall_cnt[k] < 65535) m_stall_cnt[k]++;
        if ((e_fa[k] != 0 || e_fb[k] != 0) && m_fwd_cnt[k] < 65535) m_fwd_cnt[k]++;
        if (bus0.mem_ack && m_pend[k] >= 0) begin
          m_busy[k][m_pend[k]] = 1'b0;
          m_pend[k] = -1;
        end
        if (bus0.mem_req && bus0.mem_reg_write && !(k == 1 && bus0.mem_rd == 2'd0)) begin
          m_busy[k][bus0.mem_rd] = 1'b1;
          m_pend[k] = int'(bus0.mem_rd);
        end
        if (m_waiting[k]) begin
          if (bus0.mem_ack) m_waiting[k] = 0;
          else begin
            if (m_wait_cnt[k] == MAX_WAIT) m_tout[k] = 1;
            if (m_wait_cnt[k] < 255) m_wait_cnt[k]++;
          end
        end else if (m_flush_left[k] > 0) begin
          if (bus0.branch_taken) m_flush_left[k] = FLUSH_CYC;
          else m_flush_left[k]--;
        end else if (bus0.branch_taken) begin
          m_flush_left[k] = FLUSH_CYC;
        end else if (bus0.mem_req && !bus0.mem_ack) begin
          m_waiting[k]  = 1;
          m_wait_cnt[k] = 0;
        end
      end
    end
  endtask

  // Let inputs settle, then compare both instances with the model.
  task automatic settle();
    #1;
    compute_expected();
    check("i0_fwd_a", bus0.forward_a,   e_fa[0]);
    check("i0_fwd_b", bus0.forward_b,   e_fb[0]);
    check("i0_stall", bus0.stall,       e_stall[0]);
    check("i0_flush", bus0.flush,       m_flush_left[0] > 0);
    check("i0_busy",  bus0.busy_regs,   m_busy[0]);
    check("i0_tout",  bus0.mem_timeout, m_tout[0]);
    check("i1_fwd_a", bus1.forward_a,   e_fa[1]);
    check("i1_fwd_b", bus1.forward_b,   e_fb[1]);
    check("i1_stall", bus1.stall,       e_stall[1]);
    check("i1_flush", bus1.flush,       m_flush_left[1] > 0);
    check("i1_busy",  bus1.busy_regs,   m_busy[1]);
    check("i1_tout",  bus1.mem_timeout, m_tout[1]);
`ifdef HAZARD_STATS_EN
    check("i0_stall_cycles", bus0.stall_cycles, m_stall_cnt[0]);
    check("i0_fwd_events",   bus0.fwd_events,   m_fwd_cnt[0]);
    check("i1_stall_cycles", bus1.stall_cycles, m_stall_cnt[1]);
    check("i1_fwd_events",   bus1.fwd_events,   m_fwd_cnt[1]);
`endif
  endtask

  task automatic adv();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  task automatic clr();
    bus0.id_valid = 0; bus0.id_rs = '0; bus0.id_rt = '0;
    bus0.ex_rd = '0; bus0.mem_rd = '0; bus0.wb_rd = '0;
    bus0.ex_reg_write = 0; bus0.mem_reg_write = 0; bus0.wb_reg_write = 0;
    bus0.ex_mem_read = 0; bus0.mem_req = 0; bus0.mem_ack = 0; bus0.branch_taken = 0;
  endtask

  task automatic set_load_use(input logic [1:0] r);
    bus0.id_valid = 1; bus0.ex_mem_read = 1; bus0.ex_reg_write = 1;
    bus0.ex_rd = r; bus0.id_rs = r;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    model_clear(0);
    model_clear(1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state with idle inputs.
    settle();
    check("rst_busy", bus0.busy_regs, 4'b0000);
    check("rst_flush", bus0.flush, 1'b0);
    adv();

    // Load-use stall and release; EX forward once the load has gone.
    set_load_use(2'd2);
    settle();
    check("t1_stall", bus0.stall, 1'b1);
    check("t1_fwd_a", bus0.forward_a, FWD_RF);
    adv();
    bus0.ex_mem_read = 0;
    settle();
    check("t1_release", bus0.stall, 1'b0);
    check("t1_fwd_ex", bus0.forward_a, FWD_EX);
    adv();

    // Forwarding priority on operand B.
    clr();
    bus0.id_valid = 1; bus0.id_rt = 2'd1;
    bus0.ex_rd = 2'd1; bus0.mem_rd = 2'd1; bus0.wb_rd = 2'd1;
    bus0.ex_reg_write = 1; bus0.mem_reg_write = 1; bus0.wb_reg_write = 1;
    settle(); check("t2_ex",  bus0.forward_b, FWD_EX);  adv();
    bus0.ex_reg_write = 0;
    settle(); check("t2_mem", bus0.forward_b, FWD_MEM); adv();
    bus0.mem_reg_write = 0;
    settle(); check("t2_wb",  bus0.forward_b, FWD_WB);  adv();

    // Scoreboarded multi-cycle load to r3, ack on the fourth wait cycle.
    clr();
    bus0.mem_req = 1; bus0.mem_rd = 2'd3; bus0.mem_reg_write = 1;
    tick();
    clr();
    bus0.id_valid = 1; bus0.id_rs = 2'd3;
    for (int i = 1; i <= 4; i++) begin
      bus0.mem_ack = (i == 4);
      settle();
      check("t3_busy", bus0.busy_regs, 4'b1000);
      check("t3_stall", bus0.stall, 1'b1);
      adv();
    end
    bus0.mem_ack = 0;
    settle();
    check("t3_cleared", bus0.busy_regs, 4'b0000);
    check("t3_nostall", bus0.stall, 1'b0);
    adv();

    // Branch flush for FLUSH_CYC cycles; load-use is masked during it.
    clr();
    bus0.branch_taken = 1;
    settle(); check("t4_flush_t0", bus0.flush, 1'b0); adv();
    bus0.branch_taken = 0;
    set_load_use(2'd1);
    for (int i = 0; i < FLUSH_CYC; i++) begin
      settle();
      check("t4_flush", bus0.flush, 1'b1);
      check("t4_masked", bus0.stall, 1'b0);
      adv();
    end
    settle();
    check("t4_flush_end", bus0.flush, 1'b0);
    check("t4_lu_back", bus0.stall, 1'b1);
    adv();

    // Branch and load-use together in RUN: stall now, flush from next edge.
    bus0.branch_taken = 1;
    settle();
    check("t4b_stall", bus0.stall, 1'b1);
    check("t4b_noflush", bus0.flush, 1'b0);
    adv();
    bus0.branch_taken = 0;
    settle();
    check("t4b_flush", bus0.flush, 1'b1);
    check("t4b_stall_off", bus0.stall, 1'b0);
    adv();
    clr();
    repeat (2) tick();

    // Register 0 never matches when ignored.
    set_load_use(2'd0);
    settle();
    check("t6_i1_stall", bus1.stall, 1'b0);
    check("t6_i1_fwd_a", bus1.forward_a, FWD_RF);
    check("t6_i0_stall", bus0.stall, 1'b1);
    adv();

    // Reset during an access drops the load; a later ack changes nothing.
    clr();
    bus0.mem_req = 1; bus0.mem_rd = 2'd2; bus0.mem_reg_write = 1;
    tick();
    clr();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus0.mem_ack = 1;
    settle();
    check("rst_mid_busy", bus0.busy_regs, 4'b0000);
    adv();
    clr();
    settle();
    check("rst_mid_busy2", bus0.busy_regs, 4'b0000);
    check("rst_mid_stall", bus0.stall, 1'b0);
    adv();

    // Timeout: sets after MAX_WAIT+1 wait cycles, sticky until reset.
    bus0.mem_req = 1; bus0.mem_rd = 2'd1; bus0.mem_reg_write = 1;
    tick();
    clr();
    for (int i = 1; i <= MAX_WAIT + 1; i++) begin
      settle();
      check("t5_not_yet", bus0.mem_timeout, 1'b0);
      adv();
    end
    bus0.mem_ack = 1;
    settle(); check("t5_set", bus0.mem_timeout, 1'b1); adv();
    clr();
    settle(); check("t5_sticky", bus0.mem_timeout, 1'b1); adv();
    rst_n = 1'b0;
    settle(); check("t5_sync_rst", bus0.mem_timeout, 1'b1); adv();
    rst_n = 1'b1;
    settle(); check("t5_cleared", bus0.mem_timeout, 1'b0); adv();

    // Randomised traffic, one access outstanding at a time.
    for (int c = 0; c < 600; c++) begin
      clr();
      bus0.id_valid      = ($urandom_range(0, 3) != 0);
      bus0.id_rs         = W'($urandom_range(0, 3));
      bus0.id_rt         = W'($urandom_range(0, 3));
      bus0.ex_rd         = W'($urandom_range(0, 3));
      bus0.mem_rd        = W'($urandom_range(0, 3));
      bus0.wb_rd         = W'($urandom_range(0, 3));
      bus0.ex_reg_write  = $urandom_range(0, 1) != 0;
      bus0.mem_reg_write = $urandom_range(0, 1) != 0;
      bus0.wb_reg_write  = $urandom_range(0, 1) != 0;
      bus0.ex_mem_read   = $urandom_range(0, 3) == 0;
      bus0.branch_taken  = $urandom_range(0, 9) == 0;
      bus0.mem_req       = !m_waiting[0] && (m_pend[0] < 0) && ($urandom_range(0, 7) == 0);
      bus0.mem_ack       = (m_waiting[0] || m_pend[0] >= 0) && ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
